mmio_port: RTL and testbench
============================

Name: mmio_port

Overview:
- Memory-mapped peripheral that responds on the processor's data-memory bus (memwrite, dataadr, writedata, readdata), alongside the data memory.
- Provides four word registers:
  - an outbound word FIFO drained through a valid/ready stream;
  - a status register;
  - a free-running cycle counter;
  - a compare register with a sticky match flag.
- The top level uses `hit` to choose between this block's readdata and the data memory's readdata.

Parameters:
- BASE, 32'hFFFF0000, base address of the 16-byte register window; BASE[3:0] must be 0.
- DEPTH, 8, number of FIFO entries; must be a power of 2, at most 16.
- AW, 3, log2(DEPTH).

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- memwrite  in  1  processor store strobe.
- dataadr  in  32  processor data address.
- writedata  in  32  processor store data.
- readdata  out  32  register read data; combinational from dataadr and current state.
- hit  out  1  dataadr[31:4] == BASE[31:4]; combinational.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Decode:
  - Register index is dataadr[3:2]; dataadr[1:0] is ignored.
  - wr = memwrite & hit.
  - When hit = 0: readdata = 0 and no state changes from bus writes.
- Register map (offset: read / write):
  - 0x0 TXDATA: read returns head word, or 0 if empty. Write pushes writedata.
  - 0x4 STATUS: read = {20'b0, count[3:0], 4'b0, match, ovf, full, empty}. Write: writedata[2]=1 clears ovf; writedata[3]=1 clears match; other bits ignored.
  - 0x8 CYCLE: read returns the counter. Write loads writedata.
  - 0xC CMP: read returns cmp. Write loads writedata and clears match.
- FIFO:
  - Circular buffer with rd_ptr and wr_ptr of AW bits each, plus count of AW+1 bits. Pointers wrap modulo DEPTH.
  - pop = out_valid & out_ready.
  - push_req = wr & (index == 0).
  - A push is accepted if !full, or if pop is asserted in the same cycle. When full and popping, push and pop both occur and count is unchanged.
  - A push request when full and not popping is dropped: the FIFO is unchanged and ovf is set (sticky).
  - Count update: push only: count+1. Pop only: count-1. Both: unchanged.
  - out_data is the head entry; its value is don't-care when empty.
  - empty = (count == 0); full = (count == DEPTH).
- Cycle counter:
  - Increments by 1 every cycle, modulo 2^32; 32'hFFFFFFFF wraps to 0.
  - A write to CYCLE overrides the increment: the next value is writedata, and it increments again from the following cycle.
- Match flag:
  - Set when the registered cycle value equals cmp (compare on current values).
  - Sticky until cleared by a STATUS write with bit3 = 1, or by any CMP write.
  - A clear and a set in the same cycle: set wins, except a CMP write always clears.
  - An ovf clear and a new overflow in the same cycle cannot coincide, because they target different indices.
- Latency:
  - Writes are visible in readdata and on the stream outputs the cycle after the edge.
  - Reads are zero-latency, as the single-cycle processor requires.
- Reset (synchronous; reset has priority over all writes and pops):
  - count = 0, rd_ptr = 0, wr_ptr = 0.
  - ovf = 0, match = 0.
  - cycle = 0, cmp = 32'hFFFFFFFF.
  - Resulting outputs: out_valid = 0; readdata = 0 unless hit.
  - Reset asserted mid-stream discards all FIFO contents; FIFO storage itself is not cleared.

Test Plan:
- Reset, then read BASE+4 -> readdata = 32'h00000001 (empty). Read BASE+C -> 32'hFFFFFFFF. out_valid = 0.
- With out_ready = 0, store 1..9 to BASE+0 over 9 cycles -> after 8 pushes STATUS = 32'h00000802 (count 8, full); 9th store sets ovf, giving STATUS = 32'h00000806. Store 4 to BASE+4 -> STATUS = 32'h00000802.
- With the FIFO full and out_ready = 1, store 32'hA5 in the same cycle -> out_data sequence 1,2,...,8 then 32'hA5. Count stays 8 during the simultaneous cycle; ovf stays 0.
- Store 32'hFFFFFFFE to BASE+8 -> CYCLE reads 32'hFFFFFFFE, then 32'hFFFFFFFF, then 32'h00000000 on successive cycles.
- Store 100 to BASE+C, then 95 to BASE+8 -> match (STATUS bit3) reads 1 starting 6 cycles after the CYCLE write and stays 1. A further CMP write clears it.
- dataadr = 32'h00000010 with memwrite = 1 -> hit = 0, readdata = 0, and no register or FIFO state changes.

Source files
------------

// File: rtl/mmio_port.sv
// Memory-mapped port on the data-memory bus: an outbound word FIFO streamed
// out over valid/ready, plus status, free-running cycle counter and compare registers.
module mmio_port #(
  parameter logic [31:0] BASE  = 32'hFFFF0000,
  parameter int          DEPTH = 8,
  parameter int          AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        hit,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    REG_TX     = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_CMP    = 2'd3
  } reg_idx_e;

  logic [31:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          ovf, match;
  logic [31:0]   cycle, cmp;

  reg_idx_e idx;
  logic     wr, empty, full, pop, push_req, push;
  logic     wr_status, wr_cycle, wr_cmp;
  logic [3:0] count4;
  logic       unused_addr_bits;

  assign hit       = (dataadr[31:4] == BASE[31:4]);
  assign idx       = reg_idx_e'(dataadr[3:2]);
  assign wr        = memwrite & hit;
  assign unused_addr_bits = ^dataadr[1:0];

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign out_valid = ~empty;
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push_req  = wr & (idx == REG_TX);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req & (~full | pop);

  assign wr_status = wr & (idx == REG_STATUS);
  assign wr_cycle  = wr & (idx == REG_CYCLE);
  assign wr_cmp    = wr & (idx == REG_CMP);
  assign count4    = 4'(count);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    readdata = '0;
    if (hit) begin
      unique case (idx)
        REG_TX:     readdata = empty ? 32'h0 : out_data;
        REG_STATUS: readdata = {20'b0, count4, 4'b0, match, ovf, full, empty};
        REG_CYCLE:  readdata = cycle;
        REG_CMP:    readdata = cmp;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf   <= 1'b0;
      match <= 1'b0;
      cycle <= '0;
      cmp   <= 32'hFFFFFFFF;
    end else begin
      if (push_req && full && !pop)       ovf <= 1'b1;
      else if (wr_status && writedata[2]) ovf <= 1'b0;

      cycle <= wr_cycle ? writedata : cycle + 32'd1;
      if (wr_cmp) cmp <= writedata;

      // A CMP write always clears; otherwise a fresh match beats a STATUS clear.
      if (wr_cmp)                         match <= 1'b0;
      else if (cycle == cmp)              match <= 1'b1;
      else if (wr_status && writedata[3]) match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_port.sv
// Directed-vector bench for mmio_port: FIFO fill/overflow/stream-through,
// cycle counter wrap, compare/match timing and out-of-window isolation.
module tb_mmio_port;

  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr, writedata, readdata, out_data;
  logic        hit, out_valid, out_ready;

  int checks = 0;
  int errors = 0;

  mmio_port dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .hit(hit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled before the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    memwrite  = 1'b1;
    dataadr   = addr;
    writedata = data;
    step();
    memwrite  = 1'b0;
    writedata = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    memwrite = 1'b0;
    dataadr  = addr;
    #1;
    data = readdata;
  endtask

  logic [31:0] rd;
  logic [31:0] expect_seq [9];

  initial begin
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    bus_read(BASE + 32'h4, rd); check("reset_status", rd, 32'h00000001);
    bus_read(BASE + 32'hC, rd); check("reset_cmp", rd, 32'hFFFFFFFF);
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    bus_read(BASE + 32'h0, rd); check("reset_txdata_empty", rd, 32'h0);

    // Fill to full, then overflow
    for (int i = 1; i <= 9; i++) begin
      bus_write(BASE, 32'(i));
      if (i == 8) begin
        bus_read(BASE + 32'h4, rd); check("status_full", rd, 32'h00000802);
      end
    end
    bus_read(BASE + 32'h4, rd); check("status_ovf", rd, 32'h00000806);
    bus_read(BASE + 32'h0, rd); check("txdata_head", rd, 32'h1);
    bus_write(BASE + 32'h4, 32'h4);
    bus_read(BASE + 32'h6, rd); check("status_ovf_clr", rd, 32'h00000802);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) expect_seq[i] = 32'(i + 1);
    expect_seq[8] = 32'hA5;
    out_ready = 1'b1;
    memwrite = 1'b1; dataadr = BASE; writedata = 32'hA5;
    #1;
    check("stream_0", out_data, expect_seq[0]);
    step();
    memwrite = 1'b0;
    bus_read(BASE + 32'h4, rd); check("status_pushpop", rd, 32'h00000802);
    for (int i = 1; i < 9; i++) begin
      check("stream_valid", {31'b0, out_valid}, 32'h1);
      check($sformatf("stream_%0d", i), out_data, expect_seq[i]);
      step();
    end
    check("stream_drained", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;
    bus_read(BASE + 32'h4, rd); check("status_drained", rd, 32'h00000001);

    // Cycle counter load and wrap
    bus_write(BASE + 32'h8, 32'hFFFFFFFE);
    bus_read(BASE + 32'h8, rd); check("cycle_load", rd, 32'hFFFFFFFE);
    step();
    bus_read(BASE + 32'h8, rd); check("cycle_max", rd, 32'hFFFFFFFF);
    step();
    bus_read(BASE + 32'h8, rd); check("cycle_wrap", rd, 32'h00000000);

    // Compare/match: cycle passed FFFFFFFF == reset cmp, so match is already set
    bus_read(BASE + 32'h4, rd); check("match_from_wrap", rd, 32'h00000009);
    bus_write(BASE + 32'hC, 32'd100);
    bus_read(BASE + 32'h4, rd); check("match_cmp_clr", rd, 32'h00000001);
    bus_write(BASE + 32'h8, 32'd95);
    for (int i = 1; i <= 8; i++) begin
      step();
      bus_read(BASE + 32'h4, rd);
      check($sformatf("match_t%0d", i), rd, (i >= 6) ? 32'h00000009 : 32'h00000001);
    end
    bus_write(BASE + 32'h4, 32'h8);
    bus_read(BASE + 32'h4, rd); check("match_status_clr", rd, 32'h00000001);
    bus_write(BASE + 32'hC, 32'd5);
    bus_read(BASE + 32'hC, rd); check("cmp_readback", rd, 32'd5);

    // Out-of-window accesses touch nothing
    bus_write(BASE, 32'h77);
    memwrite = 1'b1; dataadr = 32'h00000010; writedata = 32'h0000000C;
    #1;
    check("miss_hit", {31'b0, hit}, 32'h0);
    check("miss_readdata", readdata, 32'h0);
    step();
    dataadr = 32'h0000001C;
    step();
    dataadr = 32'h00000018;
    step();
    memwrite = 1'b0;
    bus_read(BASE + 32'h4, rd); check("miss_status", rd, 32'h00000100);
    bus_read(BASE + 32'h0, rd); check("miss_txdata", rd, 32'h77);
    bus_read(BASE + 32'hC, rd); check("miss_cmp", rd, 32'd5);
    bus_read(BASE + 32'h8, rd);
    check("miss_cycle_running", {31'b0, rd > 32'd100}, 32'h1);

    // Reset mid-stream discards FIFO contents
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset2_valid", {31'b0, out_valid}, 32'h0);
    bus_read(BASE + 32'hC, rd); check("reset2_cmp", rd, 32'hFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
